// File: rtl/mainm_arbiter.sv
// mainm_arbiter: shares the single main-memory port between two masters.
// The grant is held until the owning access or burst has fully completed.
module mainm_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    input  logic        m0_burst_en,
    input  logic [7:0]  m0_burst_length,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    input  logic        m1_burst_en,
    input  logic [7:0]  m1_burst_length,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    output logic        s_burst_en,
    output logic [7:0]  s_burst_length,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last;
    logic [7:0] cnt;
    logic       req0;
    logic       req1;
    logic       own0;
    logic       own1;
    logic [7:0] words0;
    logic [7:0] words1;

    assign req0  = m0_we | m0_rd;
    assign req1  = m1_we | m1_rd;
    assign own0  = (state == OWN0);
    assign own1  = (state == OWN1);
    assign grant = {own1, own0};

    // A zero burst length still moves one word.
    assign words0 = !m0_burst_en ? 8'd1 :
                    (m0_burst_length == 8'd0) ? 8'd1 :
                    m0_burst_length;
    assign words1 = !m1_burst_en ? 8'd1 :
                    (m1_burst_length == 8'd0) ? 8'd1 :
                    m1_burst_length;

    // Pick an owner from IDLE; release after the final word.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = (FIXED_PRIO || last) ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (s_ready && cnt == 8'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, last owner and remaining-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (state_nxt == OWN0) begin
                    last <= 1'b0;
                    cnt  <= words0;
                end else if (state_nxt == OWN1) begin
                    last <= 1'b1;
                    cnt  <= words1;
                end
            end else if (s_ready) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Forward the owner's handshake; everyone else sees zeros.
    always_comb begin
        s_a            = '0;
        s_d            = '0;
        s_we           = 1'b0;
        s_rd           = 1'b0;
        s_burst_en     = 1'b0;
        s_burst_length = '0;
        m0_spo         = '0;
        m0_ready       = 1'b0;
        m1_spo         = '0;
        m1_ready       = 1'b0;
        unique case (1'b1)
            own0: begin
                s_a            = m0_a;
                s_d            = m0_d;
                s_we           = m0_we;
                s_rd           = m0_rd;
                s_burst_en     = m0_burst_en;
                s_burst_length = m0_burst_length;
                m0_spo         = s_spo;
                m0_ready       = s_ready;
            end
            own1: begin
                s_a            = m1_a;
                s_d            = m1_d;
                s_we           = m1_we;
                s_rd           = m1_rd;
                s_burst_en     = m1_burst_en;
                s_burst_length = m1_burst_length;
                m1_spo         = s_spo;
                m1_ready       = s_ready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mainm_arbiter.sv
// tb_mainm_arbiter: directed and random checks of the two-master arbiter.
// A transaction-level owner model is compared with the DUT every cycle.
module tb_mainm_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_a = '0, m0_d = '0, m1_a = '0, m1_d = '0;
    logic        m0_we = 0, m0_rd = 0, m0_burst_en = 0;
    logic        m1_we = 0, m1_rd = 0, m1_burst_en = 0;
    logic [7:0]  m0_burst_length = '0, m1_burst_length = '0;
    logic [31:0] m0_spo, m1_spo, s_a, s_d;
    logic        m0_ready, m1_ready, s_we, s_rd, s_burst_en;
    logic [7:0]  s_burst_length;
    logic [31:0] s_spo = '0;
    logic        s_ready = 1'b0;
    logic [1:0]  grant;

    logic        f_m0_rd = 0, f_m1_rd = 0;
    logic [31:0] f_m0_spo, f_m1_spo, f_s_a, f_s_d;
    logic        f_m0_ready, f_m1_ready, f_s_we, f_s_rd, f_s_ben;
    logic [7:0]  f_s_blen;
    logic        f_s_ready = 1'b0;
    logic [1:0]  f_grant;

    int checks = 0;
    int errors = 0;
    bit done0 = 0;
    bit done1 = 0;
    logic [1:0] grants[$];

    always #5 clk = ~clk;

    mainm_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
        .m0_burst_en(m0_burst_en), .m0_burst_length(m0_burst_length),
        .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
        .m1_burst_en(m1_burst_en), .m1_burst_length(m1_burst_length),
        .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
        .s_burst_en(s_burst_en), .s_burst_length(s_burst_length),
        .s_spo(s_spo), .s_ready(s_ready), .grant(grant)
    );

    mainm_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_a(32'h10), .m0_d(32'h0), .m0_we(1'b0), .m0_rd(f_m0_rd),
        .m0_burst_en(1'b0), .m0_burst_length(8'd0),
        .m0_spo(f_m0_spo), .m0_ready(f_m0_ready),
        .m1_a(32'h20), .m1_d(32'h0), .m1_we(1'b0), .m1_rd(f_m1_rd),
        .m1_burst_en(1'b0), .m1_burst_length(8'd0),
        .m1_spo(f_m1_spo), .m1_ready(f_m1_ready),
        .s_a(f_s_a), .s_d(f_s_d), .s_we(f_s_we), .s_rd(f_s_rd),
        .s_burst_en(f_s_ben), .s_burst_length(f_s_blen),
        .s_spo(32'hCAFE0000), .s_ready(f_s_ready), .grant(f_grant)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Owner model: -1 idle, else master index; counts words left.
    int mdl_owner = -1;
    int mdl_left  = 0;
    int mdl_last  = 1;

    function automatic int words_of(input logic be, input logic [7:0] bl);
        if (!be || bl == 8'd0) return 1;
        return int'(bl);
    endfunction

    function automatic int pick(input logic r0, input logic r1, input int lst);
        if (r0 && r1) return (lst == 1) ? 0 : 1;
        return r0 ? 0 : 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_owner <= -1;
            mdl_left  <= 0;
            mdl_last  <= 1;
        end else if (mdl_owner < 0) begin
            if (m0_we | m0_rd | m1_we | m1_rd) begin
                mdl_owner <= pick(m0_we | m0_rd, m1_we | m1_rd, mdl_last);
                mdl_last  <= pick(m0_we | m0_rd, m1_we | m1_rd, mdl_last);
                mdl_left  <= (pick(m0_we | m0_rd, m1_we | m1_rd, mdl_last) == 0)
                    ? words_of(m0_burst_en, m0_burst_length)
                    : words_of(m1_burst_en, m1_burst_length);
            end
        end else if (s_ready) begin
            mdl_left <= mdl_left - 1;
            if (mdl_left == 1) mdl_owner <= -1;
        end
    end

    function automatic logic [1:0] exp_grant();
        if (mdl_owner == 0) return 2'b01;
        if (mdl_owner == 1) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [74:0] exp_s();
        if (mdl_owner == 0)
            return {m0_a, m0_d, m0_we, m0_rd, m0_burst_en, m0_burst_length};
        if (mdl_owner == 1)
            return {m1_a, m1_d, m1_we, m1_rd, m1_burst_en, m1_burst_length};
        return '0;
    endfunction

    // Compare every output against the model in mid-cycle.
    always @(negedge clk) begin
        chk("grant", grant, exp_grant());
        chk("s_port", {s_a, s_d, s_we, s_rd, s_burst_en, s_burst_length},
            exp_s());
        chk("m0_resp", {m0_spo, m0_ready},
            (mdl_owner == 0) ? {s_spo, s_ready} : 33'd0);
        chk("m1_resp", {m1_spo, m1_ready},
            (mdl_owner == 1) ? {s_spo, s_ready} : 33'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int idx, input logic we, input logic rd,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic be, input logic [7:0] bl);
        if (idx == 0) begin
            m0_we = we; m0_rd = rd; m0_a = a; m0_d = d;
            m0_burst_en = be; m0_burst_length = bl;
        end else begin
            m1_we = we; m1_rd = rd; m1_a = a; m1_d = d;
            m1_burst_en = be; m1_burst_length = bl;
        end
    endtask

    function automatic logic rdy(input int idx);
        return (idx == 0) ? m0_ready : m1_ready;
    endfunction

    // One master issuing n accesses; fixed mode = back-to-back reads.
    task automatic master_run(input int idx, input int n, input bit fixed);
        for (int k = 0; k < n; k++) begin
            int idle, words, got, guard;
            logic rd, be;
            logic [7:0] bl;
            idle = fixed ? 0 : $urandom_range(0, 3);
            repeat (idle) tick();
            rd = fixed ? 1'b1 : 1'($urandom_range(0, 1));
            be = fixed ? 1'b0 : 1'($urandom_range(0, 1));
            bl = fixed ? 8'd0 : 8'($urandom_range(0, 5));
            words = words_of(be, bl);
            drive_m(idx, !rd, rd, $urandom, $urandom, be, bl);
            got = 0;
            guard = 0;
            while (got < words && guard < 300) begin
                @(negedge clk);
                if (rdy(idx)) got++;
                @(posedge clk);
                #1;
                guard++;
            end
            chk("words_done", got, words);
            drive_m(idx, 0, 0, '0, '0, 0, '0);
        end
        if (idx == 0) done0 = 1;
        else done1 = 1;
    endtask

    // Memory port answering each word after 0..maxd extra cycles.
    task automatic mem_run(input int maxd);
        int wc = 0;
        int cyc = 0;
        while (!(done0 && done1) && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            s_ready = 0;
            if (s_rd | s_we) begin
                if (wc == 0) begin
                    s_ready = 1;
                    s_spo = $urandom;
                    wc = $urandom_range(0, maxd);
                end else begin
                    wc--;
                end
            end
        end
        chk("mem_budget", cyc < 20000, 1);
        s_ready = 0;
    endtask

    task automatic rec_run();
        logic [1:0] prev = 2'b00;
        while (!(done0 && done1)) begin
            @(negedge clk);
            if (grant != 2'b00 && prev == 2'b00) grants.push_back(grant);
            prev = grant;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n0, n1, guard;
        logic [1:0] prevg;
        logic [1:0] fq[$];

        m0_rd = 1; m1_rd = 1; s_ready = 1; s_spo = 32'hFFFFFFFF;
        #3;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_rd", s_rd, 0);
        chk("rst_m0_ready", m0_ready, 0);
        chk("rst_m1_spo", m1_spo, 0);
        m0_rd = 0; m1_rd = 0; s_ready = 0; s_spo = '0;
        repeat (2) tick();
        rst = 0;
        tick();

        m0_rd = 1; m0_a = 32'h100;
        tick();
        chk("rd_grant", grant, 2'b01);
        chk("rd_s_a", s_a, 32'h100);
        chk("mdl_grant", exp_grant(), 2'b01);
        tick();
        tick();
        s_ready = 1; s_spo = 32'hDEADBEEF;
        #1;
        chk("rd_m0_spo", m0_spo, 32'hDEADBEEF);
        chk("rd_m0_ready", m0_ready, 1);
        chk("rd_m1_ready", m1_ready, 0);
        tick();
        chk("rd_release", grant, 2'b00);
        chk("rd_ready_once", m0_ready, 0);
        m0_rd = 0; s_ready = 0; s_spo = '0;
        tick();

        m1_rd = 1; m1_burst_en = 1; m1_burst_length = 8'd0;
        tick();
        chk("b0_grant", grant, 2'b10);
        s_ready = 1;
        tick();
        chk("b0_release", grant, 2'b00);
        m1_rd = 0; m1_burst_en = 0; s_ready = 0;
        tick();

        m1_rd = 1; m1_burst_en = 1; m1_burst_length = 8'd8;
        m1_a = 32'h4000;
        tick();
        for (int w = 1; w <= 8; w++) begin
            chk("bst_hold", grant, 2'b10);
            s_ready = 1;
            s_spo = 32'(w);
            if (w == 3) begin
                m0_rd = 1;
                m0_a = 32'h200;
            end
            tick();
        end
        chk("bst_bubble", grant, 2'b00);
        m1_rd = 0; m1_burst_en = 0; m1_burst_length = '0; s_ready = 0;
        tick();
        chk("bst_next", grant, 2'b01);
        s_ready = 1;
        tick();
        m0_rd = 0; s_ready = 0;
        tick();

        m0_rd = 1; m0_burst_en = 1; m0_burst_length = 8'd8;
        tick();
        s_ready = 1;
        tick();
        tick();
        #1;
        chk("ar_word3", m0_ready, 1);
        #1;
        rst = 1;
        #1;
        chk("ar_s_rd", s_rd, 0);
        chk("ar_grant", grant, 2'b00);
        chk("ar_m0_ready", m0_ready, 0);
        m0_burst_en = 0; m0_burst_length = '0; s_ready = 0; m1_rd = 1;
        tick();
        rst = 0;
        tick();
        chk("ar_first", grant, 2'b01);
        s_ready = 1; m0_rd = 0; m1_rd = 0;
        tick();
        s_ready = 0;
        chk("ar_idle", grant, 2'b00);
        tick();

        m0_we = 1; m0_d = 32'h12345678; m0_a = 32'h2000;
        tick();
        repeat (2) begin
            chk("wr_s_we", s_we, 1);
            chk("wr_s_d", s_d, 32'h12345678);
            chk("wr_s_a", s_a, 32'h2000);
            chk("wr_s_rd", s_rd, 0);
            tick();
        end
        s_ready = 1;
        tick();
        m0_we = 0; s_ready = 0;
        tick();

        rst = 1;
        tick();
        rst = 0;
        tick();
        done0 = 0; done1 = 0;
        fork
            master_run(0, 4, 1);
            master_run(1, 4, 1);
            mem_run(0);
            rec_run();
        join
        chk("rr_count", grants.size(), 8);
        foreach (grants[i])
            chk("rr_order", grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        tick();

        done0 = 0; done1 = 0;
        fork
            master_run(0, 40, 0);
            master_run(1, 40, 0);
            mem_run(3);
        join
        tick();

        f_m0_rd = 1; f_m1_rd = 1;
        n0 = 0; n1 = 0; guard = 0; prevg = 2'b00;
        while (n1 < 1 && guard < 200) begin
            @(negedge clk);
            if (f_grant != 2'b00 && prevg == 2'b00) fq.push_back(f_grant);
            prevg = f_grant;
            if (f_m0_ready) n0++;
            if (f_m1_ready) n1++;
            @(posedge clk);
            #1;
            if (n0 >= 4) f_m0_rd = 0;
            if (n1 >= 1) f_m1_rd = 0;
            f_s_ready = f_s_rd | f_s_we;
            guard++;
        end
        f_s_ready = 0;
        chk("fp_count", fq.size(), 5);
        foreach (fq[i])
            chk("fp_order", fq[i], (i < 4) ? 2'b01 : 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mainm_arbiter.md
# mainm_arbiter

Two-master arbiter that shares the single main-memory port (memory controller or on-chip main RAM) between the CPU-side path (cache or direct) and a second bus master such as a DMA engine or video fetcher. It sits between those masters and the serial-boot/memory-controller port. It forwards the bus handshake (`a`/`d`/`we`/`rd`/`spo`/`ready` plus `burst_en`/`burst_length`) from exactly one granted master. The grant is held until the granted access or burst has fully completed.

## Interface
Parameters:
- `FIXED_PRIO`, default 0: 0 = round-robin between masters; 1 = master 0 always wins simultaneous requests.

Ports:
- `clk`  in  1  main clock (`clk_main` domain).
- `rst`  in  1  reset; asynchronous, active-high.
- `m0_a`, `m0_d`  in  32 each  master 0 address and write data.
- `m0_we`, `m0_rd`  in  1 each  master 0 write and read request; held high until `m0_ready`.
- `m0_burst_en`  in  1  master 0 burst request.
- `m0_burst_length`  in  8  master 0 burst word count.
- `m0_spo`  out  32  master 0 read data.
- `m0_ready`  out  1  master 0 per-word completion pulse.
- `m1_*`  same set of signals as master 0, for master 1.
- `s_a`, `s_d`  out  32 each  address and write data to the memory port.
- `s_we`, `s_rd`, `s_burst_en`  out  1 each  requests to the memory port.
- `s_burst_length`  out  8  burst word count to the memory port.
- `s_spo`  in  32  memory port read data.
- `s_ready`  in  1  memory port per-word completion pulse.
- `grant`  out  2  one-hot current owner: bit0 = master 0, bit1 = master 1; 0 when idle.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- A master is requesting when `req_i = mi_we | mi_rd`.
- IDLE:
  - Only one master requesting → go to OWNi for that master.
  - Both requesting, `FIXED_PRIO=1` → go to OWN0.
  - Both requesting, `FIXED_PRIO=0` → go to the master not recorded in the `last` register.
  - No request → stay in IDLE.
- On entry to OWNi:
  - `last` ← i.
  - Load word counter `cnt` ← `mi_burst_en ? max(mi_burst_length,1) : 1`. A `burst_length` of 0 is treated as 1.
- OWNi forwarding (combinational):
  - All `s_*` outputs follow master i's signals.
  - `mi_spo` = `s_spo` and `mi_ready` = `s_ready`.
  - The other master sees `ready=0` and `spo=0`.
- Word counting in OWNi: each cycle with `s_ready=1` decrements `cnt`. When `s_ready=1` and `cnt==1`, go to IDLE.
- In IDLE all `s_we`, `s_rd`, `s_burst_en` are 0. `s_a`, `s_d`, `s_burst_length` are 0.
- A master that drops its request while owning the port (protocol violation) is not released early. The grant is held until the remaining `s_ready` pulses arrive.
- `last` reset value = 1, so master 0 wins the first simultaneous contest.

## Timing
- Reset: the following are 0 immediately and asynchronously: `grant`, all `s_*` request/strobe outputs, `m0_ready`, `m1_ready`, both `spo`. The FSM is in IDLE with `last=1` and `cnt=0`.
- Reset mid-transfer drops `s_rd`/`s_we` the same instant. The memory side is expected to be reset by the same tree.
- Grant latency: request seen in IDLE at edge N → state OWNi after edge N → `s_rd`/`s_we` visible in cycle N+1. Arbitration adds 1 cycle per access.
- Release: the cycle carrying the last `s_ready` is still OWNi. After that edge the state is IDLE for at least 1 cycle, which guarantees a 1-cycle bubble between owners and between back-to-back accesses of the same master.
- Round-robin with both masters continuously requesting single accesses yields the strict alternation 0,1,0,1,… `FIXED_PRIO=1` yields 0,0,0,…
- A new request arriving while the other master owns the port waits without being lost, since requests are level-held.
- `cnt` is 8 bits. Bursts of up to 255 words are counted exactly; `burst_length` values are sampled only at grant entry.

## Test plan
- Single read from m0 (`m0_rd=1`, `a=0x100`); memory returns `s_spo=0xDEADBEEF` with `s_ready` 3 cycles later → `grant=01` one cycle after the request, `m0_spo=0xDEADBEEF` and `m0_ready=1` for exactly one cycle, `grant=00` the next cycle. m1 sees `ready=0` throughout.
- Simultaneous single requests from both masters held for 4 accesses each, round-robin → grant order 0,1,0,1,…, each separated by one IDLE cycle. With `FIXED_PRIO=1` → m0 serviced 4 times before m1.
- m1 burst (`burst_en=1`, `burst_length=8`) while m0 requests at the third word → `grant=10` held through all 8 `s_ready` pulses; m0 granted only after the IDLE cycle that follows.
- Burst with `burst_length=0` → treated as 1 word; released after the first `s_ready`.
- `rst` asserted asynchronously mid-burst (word 3 of 8) → `s_rd`, `grant`, `mi_ready` go to 0 without waiting for a clock edge. After release, a simultaneous request is granted to m0 first (`last=1`).
- m0 write (`we=1`, `d=0x12345678`) → `s_we=1`, `s_d=0x12345678`, `s_a` matches `m0_a` in every OWN0 cycle; `s_rd=0`.
